// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the conv input-stream sequencer.
// Optional stall counter in conv_feed_ctrl is enabled by CONV_FEED_STALL_CNT_EN.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } conv_state_e;

  // Index width for a KK-entry weight bank; a single-entry bank still needs one bit.
  function automatic int unsigned idx_width(input int unsigned kk);
    return (kk > 1) ? $clog2(kk) : 1;
  endfunction

  localparam int unsigned KSIZE_DEF  = 3;
  localparam int unsigned KK_DEF     = KSIZE_DEF * KSIZE_DEF;
  localparam int unsigned KK_IDX_DEF = idx_width(KK_DEF);

endpackage

// File: rtl/conv_feed_ctrl_if.sv
// AXI-Stream style input beat bus feeding conv_feed_ctrl.
interface conv_feed_ctrl_if #(
  parameter int unsigned DATA_BW = 8
);

  logic                      i_s_valid;
  logic                      o_s_ready;
  logic signed [DATA_BW-1:0] i_s_data;

  modport master (
    output i_s_valid,
    output i_s_data,
    input  o_s_ready
  );

  modport slave (
    input  i_s_valid,
    input  i_s_data,
    output o_s_ready
  );

endinterface

// File: rtl/conv_pos_cnt.sv
// Row/column raster counter: column wraps at width-1 and bumps the row.
module conv_pos_cnt #(
  parameter int unsigned DIM_BW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DIM_BW-1:0] i_w,
  input  logic [DIM_BW-1:0] i_h,
  output logic [DIM_BW-1:0] o_row,
  output logic [DIM_BW-1:0] o_col,
  output logic              o_wrap,
  output logic              o_last
);

  logic [DIM_BW-1:0] r_row;
  logic [DIM_BW-1:0] r_col;

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_wrap = (r_col == i_w - DIM_BW'(1));
  // Row-level only; combined with o_wrap it marks the final pixel.
  assign o_last = (r_row == i_h - DIM_BW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_en) begin
      if (o_wrap) begin
        r_col <= '0;
        r_row <= r_row + DIM_BW'(1);
      end else begin
        r_col <= r_col + DIM_BW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_feed_ctrl.sv
// Conv input sequencer: routes KSIZE*KSIZE weight beats, then img_w*img_h pixels.
// Define CONV_FEED_STALL_CNT_EN to add the o_stall_cnt valid-gap counter.
module conv_feed_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned DATA_BW = 8,
  parameter int unsigned DIM_BW  = 8,
  parameter int unsigned KSIZE   = 3
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_start,
  input  logic [DIM_BW-1:0]                     i_img_w,
  input  logic [DIM_BW-1:0]                     i_img_h,
  output logic                                  o_busy,
  output logic                                  o_done,
  conv_feed_ctrl_if.slave                       s_if,
  output logic                                  o_w_we,
  output logic [idx_width(KSIZE*KSIZE)-1:0]     o_w_idx,
  output logic signed [DATA_BW-1:0]             o_w_data,
  output logic                                  o_px_valid,
  output logic [DIM_BW-1:0]                     o_row,
  output logic [DIM_BW-1:0]                     o_col,
  output logic                                  o_win_valid,
  output logic                                  o_last
`ifdef CONV_FEED_STALL_CNT_EN
  ,
  output logic [31:0]                           o_stall_cnt
`endif
);

  localparam int unsigned KK_L  = KSIZE * KSIZE;
  localparam int unsigned IDX_W = idx_width(KK_L);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(KK_L - 1);
  localparam logic [DIM_BW-1:0] WIN_MIN  = DIM_BW'(KSIZE - 1);

  conv_state_e               r_state;
  logic [DIM_BW-1:0]         r_img_w;
  logic [DIM_BW-1:0]         r_img_h;
  logic [IDX_W-1:0]          r_wcnt;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_w_we;
  logic [IDX_W-1:0]          r_w_idx;
  logic signed [DATA_BW-1:0] r_w_data;
  logic                      r_px_valid;
  logic [DIM_BW-1:0]         r_row;
  logic [DIM_BW-1:0]         r_col;
  logic                      r_win_valid;
  logic                      r_last;

  logic                      w_hs;
  logic                      w_start_acc;
  logic                      w_pos_en;
  logic [DIM_BW-1:0]         w_cnt_row;
  logic [DIM_BW-1:0]         w_cnt_col;
  logic                      w_cnt_wrap;
  logic                      w_cnt_row_last;
  logic                      w_final_px;

  assign s_if.o_s_ready = (r_state == ST_LOAD_W) || (r_state == ST_FEED);
  assign w_hs           = s_if.i_s_valid && s_if.o_s_ready;
  assign w_start_acc    = (r_state == ST_IDLE) && i_start;
  assign w_pos_en       = (r_state == ST_FEED) && w_hs;
  assign w_final_px     = w_cnt_wrap && w_cnt_row_last;

  conv_pos_cnt #(
    .DIM_BW (DIM_BW)
  ) u_pos_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_start_acc),
    .i_en   (w_pos_en),
    .i_w    (r_img_w),
    .i_h    (r_img_h),
    .o_row  (w_cnt_row),
    .o_col  (w_cnt_col),
    .o_wrap (w_cnt_wrap),
    .o_last (w_cnt_row_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_img_w     <= '0;
      r_img_h     <= '0;
      r_wcnt      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_w_we      <= 1'b0;
      r_w_idx     <= '0;
      r_w_data    <= '0;
      r_px_valid  <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
      r_win_valid <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      r_w_we      <= 1'b0;
      r_px_valid  <= 1'b0;
      r_win_valid <= 1'b0;
      r_last      <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_img_w <= i_img_w;
            r_img_h <= i_img_h;
            r_wcnt  <= '0;
            // Empty image: skip straight to completion without touching the stream.
            if ((i_img_w == '0) || (i_img_h == '0)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_LOAD_W;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_LOAD_W: begin
          if (w_hs) begin
            r_w_we   <= 1'b1;
            r_w_idx  <= r_wcnt;
            r_w_data <= s_if.i_s_data;
            r_wcnt   <= r_wcnt + IDX_W'(1);
            if (r_wcnt == LAST_IDX) begin
              r_state <= ST_FEED;
            end
          end
        end
        ST_FEED: begin
          if (w_hs) begin
            r_px_valid  <= 1'b1;
            r_row       <= w_cnt_row;
            r_col       <= w_cnt_col;
            r_win_valid <= (w_cnt_row >= WIN_MIN) && (w_cnt_col >= WIN_MIN);
            r_last      <= w_final_px;
            if (w_final_px) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONV_FEED_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_start_acc) begin
      r_stall_cnt <= '0;
    end else if (s_if.o_s_ready && !s_if.i_s_valid && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_w_we      = r_w_we;
  assign o_w_idx     = r_w_idx;
  assign o_w_data    = r_w_data;
  assign o_px_valid  = r_px_valid;
  assign o_row       = r_row;
  assign o_col       = r_col;
  assign o_win_valid = r_win_valid;
  assign o_last      = r_last;

endmodule

// File: doc/conv_feed_ctrl.md
Name:
conv_feed_ctrl

Overview:
- Sequencer for the conv input stream; sits between the AXI-Stream slave input and the pixel-delay stage plus kernel weight registers.
- On each job it first routes KSIZE*KSIZE weight beats into the kernel weight registers, then routes img_w*img_h pixel beats onward.
- Produces per-pixel row/col position and window-valid flags, registered one cycle so they align with the 1-cycle pixel delay stage output.

Parameters:
- DATA_BW, 8, stream/weight/pixel data width (signed).
- DIM_BW, 8, width of image dimension inputs and row/col counters.
- KSIZE, 3, kernel edge length (KSIZE >= 1); weight count = KSIZE*KSIZE.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- i_start  in  1  job start pulse; sampled only in IDLE.
- i_img_w  in  DIM_BW  image width in pixels; latched at start.
- i_img_h  in  DIM_BW  image height in pixels; latched at start.
- o_busy  out  1  high from the cycle after accepted start until DONE.
- o_done  out  1  one-cycle completion pulse.
- i_s_valid  in  1  stream beat valid.
- o_s_ready  out  1  stream ready; combinational from state only.
- i_s_data  in  DATA_BW  stream data (pixels also routed externally to the delay stage).
- o_w_we  out  1  registered weight write strobe.
- o_w_idx  out  clog2(KSIZE*KSIZE)  registered weight index, 0..KSIZE*KSIZE-1.
- o_w_data  out  DATA_BW  registered weight value.
- o_px_valid  out  1  registered; pixel present at delay-stage output this cycle.
- o_row  out  DIM_BW  registered row of that pixel.
- o_col  out  DIM_BW  registered column of that pixel.
- o_win_valid  out  1  registered; full KSIZE x KSIZE window ends at this pixel.
- o_last  out  1  registered; final pixel of the job.

Behaviour:
- Reset (rst_n asynchronous, active-low; clock clk): state IDLE.
  - All registered outputs 0; counters 0.
  - Reset mid-job abandons the job; no o_done is issued.
- States and transitions:
  - IDLE: if i_start=1, go to LOAD_W.
    - If the latched i_img_w or i_img_h is 0, go instead to DONE; no beats are accepted.
  - LOAD_W: o_s_ready=1.
    - Each handshake (i_s_valid & o_s_ready) registers o_w_we=1, o_w_idx=weight counter, o_w_data=i_s_data.
    - The weight counter increments on each handshake.
    - On handshake of index KSIZE*KSIZE-1, go to FEED.
  - FEED: o_s_ready=1. On each handshake:
    - the col counter increments;
    - at col = img_w-1 it wraps to 0 and the row counter increments.
    - On handshake of the pixel at row = img_h-1, col = img_w-1, go to DRAIN.
  - DRAIN: o_s_ready=0 for one cycle so the last delayed pixel emerges; then DONE.
  - DONE: o_done=1 for one cycle; o_busy=0; return to IDLE.
- o_busy is high in LOAD_W, FEED and DRAIN.
- Alignment: in FEED, a handshake in cycle N gives, in cycle N+1:
  - o_px_valid=1, o_row and o_col of that pixel;
  - o_win_valid = (row >= KSIZE-1) && (col >= KSIZE-1);
  - o_last = (final pixel).
  - This matches the delay stage's 1-cycle latency.
- With no handshake in cycle N, o_px_valid, o_win_valid, o_last and o_w_we are 0 in N+1; o_row, o_col, o_w_idx and o_w_data hold.
- Back-pressure: the block is always ready in LOAD_W and FEED; i_s_valid gaps simply stall the counters.
- i_start outside IDLE is ignored.
- Dimensions smaller than KSIZE: pixels stream normally, o_win_valid never asserts.
- Counter comparisons use the latched dimensions at DIM_BW width, with no overflow; max image 2^DIM_BW-1 per side.
- A weight stream beat arriving in IDLE is not accepted (ready=0).

Optional Feature:
- Macro CONV_FEED_STALL_CNT_EN.
- Defined: adds output o_stall_cnt (32 bits).
  - Counts cycles in LOAD_W or FEED with i_s_valid=0.
  - Clears on accepted i_start; saturates at all-ones; holds after DONE; 0 at reset.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package conv_pkg:
  - state encoding typedef (IDLE, LOAD_W, FEED, DRAIN, DONE);
  - localparam KK = KSIZE*KSIZE and its index width.
- One natural sub-module, conv_pos_cnt: row/col wrap counter with enable, clear, wrap and last outputs.
- The FSM and output registers stay in conv_feed_ctrl.

Test Plan:
- Basic job, KSIZE=3, img 4x4, continuous valid, weights 1..9 then pixels 0..15:
  - o_w_we for 9 cycles, idx 0..8, data 1..9;
  - o_px_valid for 16 cycles;
  - o_win_valid on (2,2), (2,3), (3,2), (3,3) only;
  - o_last with (3,3); o_done 2 cycles after the last handshake.
- Valid gaps: same job with i_s_valid toggling 1/0.
  - Same o_w/o_row/o_col sequence, o_px_valid gaps mirror input gaps, identical final result.
  - With CONV_FEED_STALL_CNT_EN, o_stall_cnt = number of low-valid cycles.
- Zero dimension: i_img_w=0, i_img_h=5, start.
  - o_s_ready never 1; o_done the cycle after DONE entry; o_busy stays 0.
- Small image: img 2x2, KSIZE=3.
  - 4 pixels accepted, o_win_valid never asserted, o_last on (1,1).
- Reset mid-FEED: assert rst_n=0 after 5 pixels.
  - All outputs 0 immediately, no o_done; a new 4x4 job then completes correctly.
- Start while busy: pulse i_start during FEED.
  - Ignored; job completes with one o_done; the next start is accepted only from IDLE.
